// File: rtl/udm_uart_pkg.sv
// Shared UART definitions for the UDM receive path and the future transmitter.
package udm_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_MIN_PERIOD = 4;

endpackage

// File: rtl/udm_uart_rx_if.sv
// Byte handshake and status bundle between udm_uart_rx and the UDM controller.
interface udm_uart_rx_if;
  import udm_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;
  logic                      ferr;
  logic                      overrun;
  logic                      busy;

  modport master (output data, valid, ferr, overrun, busy, input ready);
  modport slave  (input data, valid, ferr, overrun, busy, output ready);

endinterface

// File: rtl/udm_sync2.sv
// Two-flop synchronizer for a single asynchronous input with a configurable reset value.
module udm_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/udm_uart_rx.sv
// 8N1 UART receiver with a runtime bit period, one-byte holding register and
// framing-error / overrun pulses.
module udm_uart_rx
  import udm_uart_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned MIN_PERIOD = UART_MIN_PERIOD
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic                      rx_i,
  input  logic [PERIOD_W-1:0]       bitperiod_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      ferr_o,
  output logic                      overrun_o,
  output logic                      busy_o
);

  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE_P    = PERIOD_W'(1);
  localparam logic [2:0]          LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rxs;

  udm_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .d_i     (rx_i),
    .q_o     (rxs)
  );

  uart_state_e               state_q, state_d;
  logic [PERIOD_W-1:0]       cnt_q, cnt_d;
  logic [PERIOD_W-1:0]       period_q, period_d;
  logic [2:0]                bitidx_q, bitidx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
  logic [PERIOD_W-1:0]       period_in;
  logic                      cnt_zero;

  always_comb begin
    period_in = (bitperiod_i < MIN_P) ? MIN_P : bitperiod_i;
    cnt_zero  = (cnt_q == '0);
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - ONE_P;
    period_d  = period_q;
    bitidx_d  = bitidx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (valid_q && ready_i) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          period_d = period_in;
          cnt_d    = (period_in >> 1) - ONE_P;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_zero) begin
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d    = period_q - ONE_P;
            bitidx_d = '0;
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cnt_zero) begin
          shift_d  = {rxs, shift_q[UART_DATA_BITS-1:1]};
          cnt_d    = period_q - ONE_P;
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_zero) begin
          if (rxs) begin
            // A same-cycle accept frees the holding register, so the new byte wins.
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign ferr_o    = ferr_q;
  assign overrun_o = ovr_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udm_uart_rx.sv
// Scoreboard bench for udm_uart_rx: directed frames push expected events,
// a monitor pops them as the receiver presents bytes and pulses.
module tb_udm_uart_rx;
  import udm_uart_pkg::*;

  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          arstn;
  logic          rx;
  logic [PW-1:0] bitperiod;

  udm_uart_rx_if u_if ();

  always #5 clk = ~clk;

  udm_uart_rx #(.PERIOD_W(PW), .MIN_PERIOD(4)) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .rx_i        (rx),
    .bitperiod_i (bitperiod),
    .data_o      (u_if.data),
    .valid_o     (u_if.valid),
    .ready_i     (u_if.ready),
    .ferr_o      (u_if.ferr),
    .overrun_o   (u_if.overrun),
    .busy_o      (u_if.busy)
  );

  typedef enum int {EV_ACC, EV_FERR, EV_OVR} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_e k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input ev_e k, input logic [7:0] d);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s data 0x%02h, expected no event", k.name(), d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || (k == EV_ACC && e.data != d)) begin
        errors++;
        $display("FAIL scoreboard: got %s data 0x%02h expected %s data 0x%02h",
                 k.name(), d, e.kind.name(), e.data);
      end
    end
  endtask

  // Called at a falling clock edge; each bit lasts p cycles.
  task automatic send_byte(input logic [7:0] b, input int unsigned p);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    rx = 1'b1;
    repeat (p) @(negedge clk);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (arstn) begin
        if (u_if.valid && u_if.ready) expect_ev(EV_ACC, u_if.data);
        if (u_if.ferr)                expect_ev(EV_FERR, 8'h00);
        if (u_if.overrun)             expect_ev(EV_OVR, 8'h00);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] b;
    arstn      = 1'b0;
    rx         = 1'b1;
    bitperiod  = 16'd16;
    u_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(u_if.data),    32'h00);
    check("rst_valid", 32'(u_if.valid),   32'h0);
    check("rst_busy",  32'(u_if.busy),    32'h0);
    check("rst_ferr",  32'(u_if.ferr),    32'h0);
    check("rst_ovr",   32'(u_if.overrun), 32'h0);
    arstn = 1'b1;
    repeat (3) @(negedge clk);

    // Good byte with exact valid timing.
    u_if.ready = 1'b1;
    push(EV_ACC, 8'hA5);
    fork
      send_byte(8'hA5, 16);
      begin
        for (int i = 1; i <= 156; i++) begin
          @(negedge clk);
          if (i == 3)   check("good_busy_start", 32'(u_if.busy), 32'h1);
          if (i == 154) check("good_valid_early", 32'(u_if.valid), 32'h0);
          if (i == 155) begin
            check("good_valid", 32'(u_if.valid), 32'h1);
            check("good_data",  32'(u_if.data),  32'hA5);
          end
          if (i == 156) check("good_valid_1cyc", 32'(u_if.valid), 32'h0);
        end
      end
    join
    repeat (4) @(negedge clk);

    // Back-to-back with backpressure: second byte overruns.
    u_if.ready = 1'b0;
    push(EV_OVR, 8'h00);
    push(EV_ACC, 8'h55);
    send_byte(8'h55, 16);
    send_byte(8'h3C, 16);
    check("ovr_valid_held", 32'(u_if.valid), 32'h1);
    check("ovr_data_kept",  32'(u_if.data),  32'h55);
    u_if.ready = 1'b1;
    @(negedge clk);
    u_if.ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_drop", 32'(u_if.valid), 32'h0);

    // Same-cycle accept and load.
    push(EV_ACC, 8'h55);
    push(EV_ACC, 8'h3C);
    send_byte(8'h55, 16);
    fork
      send_byte(8'h3C, 16);
      begin
        repeat (154) @(negedge clk);
        u_if.ready = 1'b1;
        @(negedge clk);
        u_if.ready = 1'b0;
        check("same_valid", 32'(u_if.valid), 32'h1);
        check("same_data",  32'(u_if.data),  32'h3C);
      end
    join
    u_if.ready = 1'b1;
    @(negedge clk);
    u_if.ready = 1'b0;
    @(negedge clk);
    check("same_drained", 32'(u_if.valid), 32'h0);

    // Framing error followed by a held-low break.
    u_if.ready = 1'b1;
    push(EV_FERR, 8'h00);
    rx = 1'b0;
    repeat (640) @(negedge clk);
    check("brk_busy",  32'(u_if.busy),  32'h1);
    check("brk_valid", 32'(u_if.valid), 32'h0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("brk_released", 32'(u_if.busy), 32'h0);
    push(EV_ACC, 8'h0F);
    send_byte(8'h0F, 16);
    repeat (4) @(negedge clk);

    // Short glitch is a false start.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy", 32'(u_if.busy), 32'h1);
    repeat (20) @(negedge clk);
    check("glitch_idle",  32'(u_if.busy),  32'h0);
    check("glitch_valid", 32'(u_if.valid), 32'h0);

    // Bit period below the minimum is clamped to 4.
    bitperiod = 16'd1;
    push(EV_ACC, 8'h96);
    send_byte(8'h96, 4);
    repeat (4) @(negedge clk);
    check("clamp_idle", 32'(u_if.busy), 32'h0);
    bitperiod = 16'd16;

    // Reset in mid-frame with a byte waiting in the holding register.
    u_if.ready = 1'b0;
    send_byte(8'h5A, 16);
    check("pre_rst_valid", 32'(u_if.valid), 32'h1);
    b = 8'hFF;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = b[4];
    repeat (8) @(negedge clk);
    arstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(u_if.valid), 32'h0);
    check("mid_rst_data",  32'(u_if.data),  32'h00);
    check("mid_rst_busy",  32'(u_if.busy),  32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(u_if.busy), 32'h0);
    u_if.ready = 1'b1;
    push(EV_ACC, 8'hC3);
    send_byte(8'hC3, 16);
    repeat (10) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
